ldlt_fwd_solver: RTL and testbench

- Sits directly downstream of LDLT and consumes its packed-L output burst.
- Solves L·D·z = b, with b preloaded: forward substitution y = L⁻¹b runs on the fly as rows stream in, then z(i) = y(i)/D(i) is computed serially.
- The z vector is emitted as one N-word burst, in the same style as LDLT's o_valid/o_data.
- Input stream format: row-major packed lower triangle. Row i carries L(i,0..i-1), then D(i) in the diagonal slot, giving L_SIZE words. The unit diagonal of L is implicit.

---
 rtl/ldlt_fwd_solver_pkg.sv | 51 +++++
 rtl/ldlt_fwd_solver_fxp_seq_div.sv | 115 +++++++++++
 rtl/ldlt_fwd_solver.sv | 242 ++++++++++++++++++++++++
 tb/tb_ldlt_fwd_solver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldlt_fwd_solver_pkg.sv
// +----------------------------------------------------------------------+
// | ldlt_fwd_solver_pkg                                                  |
// | Shared fixed-point helpers, matrix sizing and solver FSM encoding.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ldlt_fwd_solver_pkg;

  localparam int FXP_DATA_LEN = 32;
  localparam int FXP_FRACTION = 16;
  localparam int FXP_NODE_NUM = 1;
  localparam int FXP_ACC_LEN  = 2 * FXP_DATA_LEN;

  localparam logic [FXP_DATA_LEN-1:0] FXP_MAX = {1'b0, {(FXP_DATA_LEN-1){1'b1}}};
  localparam logic [FXP_DATA_LEN-1:0] FXP_MIN = {1'b1, {(FXP_DATA_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_WAIT_L = 3'd2,
    ST_FWD    = 3'd3,
    ST_DIV    = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  function automatic int mat_order(input int node_num);
    return 6 * node_num;
  endfunction

  function automatic int l_size(input int n);
    return n * (n + 1) / 2;
  endfunction

  function automatic logic [FXP_ACC_LEN-1:0] sext_acc(input logic [FXP_DATA_LEN-1:0] v);
    return {{FXP_DATA_LEN{v[FXP_DATA_LEN-1]}}, v};
  endfunction

  // In range exactly when all bits above the result sign bit agree with it.
  function automatic logic [FXP_DATA_LEN-1:0] sat_acc(input logic [FXP_ACC_LEN-1:0] a);
    if ((&a[FXP_ACC_LEN-1:FXP_DATA_LEN-1]) || !(|a[FXP_ACC_LEN-1:FXP_DATA_LEN-1]))
      return a[FXP_DATA_LEN-1:0];
    else if (a[FXP_ACC_LEN-1])
      return FXP_MIN;
    else
      return FXP_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldlt_fwd_solver_fxp_seq_div.sv
// +----------------------------------------------------------------------+
// | fxp_seq_div                                                          |
// | Restoring signed divider, truncating, result saturated to DATA_LEN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fxp_seq_div #(
  parameter int DATA_LEN = 32,
  parameter int FRACTION = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [DATA_LEN+FRACTION-1:0] i_num,
  input  logic [DATA_LEN-1:0]          i_den,
  output logic                         o_done,
  output logic [DATA_LEN-1:0]          o_quot
);

  localparam int NW = DATA_LEN + FRACTION;
  localparam int IW = $clog2(NW);
  localparam logic [DATA_LEN-1:0] Q_MAX = {1'b0, {(DATA_LEN-1){1'b1}}};
  localparam logic [DATA_LEN-1:0] Q_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                neg_q, neg_d;
  logic [NW-1:0]       sr_q, sr_d;
  logic [DATA_LEN-1:0] den_q, den_d;
  logic [DATA_LEN-1:0] rem_q, rem_d;
  logic [IW-1:0]       it_q, it_d;

  logic [NW-1:0]       num_abs;
  logic [DATA_LEN-1:0] den_abs;
  logic [DATA_LEN:0]   rem_sh;
  logic [DATA_LEN:0]   trial;

  // sr holds the dividend magnitude; quotient bits shift in from the bottom.
  always_comb begin
    num_abs = i_num[NW-1] ? (~i_num + 1'b1) : i_num;
    den_abs = i_den[DATA_LEN-1] ? (~i_den + 1'b1) : i_den;
    rem_sh  = {rem_q, sr_q[NW-1]};
    trial   = rem_sh - {1'b0, den_q};

    run_d  = run_q;
    done_d = 1'b0;
    neg_d  = neg_q;
    sr_d   = sr_q;
    den_d  = den_q;
    rem_d  = rem_q;
    it_d   = it_q;

    if (i_start) begin
      run_d = 1'b1;
      neg_d = i_num[NW-1] ^ i_den[DATA_LEN-1];
      sr_d  = num_abs;
      den_d = den_abs;
      rem_d = '0;
      it_d  = '0;
    end else if (run_q) begin
      if (!trial[DATA_LEN]) begin
        rem_d = trial[DATA_LEN-1:0];
        sr_d  = {sr_q[NW-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DATA_LEN-1:0];
        sr_d  = {sr_q[NW-2:0], 1'b0};
      end
      it_d = it_q + 1'b1;
      if (it_q == IW'(NW - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      sr_q   <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      it_q   <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      neg_q  <= neg_d;
      sr_q   <= sr_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      it_q   <= it_d;
    end
  end

  always_comb begin
    if (neg_q) begin
      if ((|sr_q[NW-1:DATA_LEN]) || (sr_q[DATA_LEN-1] && (|sr_q[DATA_LEN-2:0])))
        o_quot = Q_MIN;
      else
        o_quot = ~sr_q[DATA_LEN-1:0] + 1'b1;
    end else begin
      if (|sr_q[NW-1:DATA_LEN-1])
        o_quot = Q_MAX;
      else
        o_quot = sr_q[DATA_LEN-1:0];
    end
  end

  assign o_done = done_q;

endmodule

`default_nettype wire

// File: rtl/ldlt_fwd_solver.sv
// +----------------------------------------------------------------------+
// | ldlt_fwd_solver                                                      |
// | Streams packed L/D rows, forward-substitutes y, divides z = y / D.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ldlt_fwd_solver
  import ldlt_fwd_solver_pkg::*;
#(
  parameter int DATA_LEN = FXP_DATA_LEN,
  parameter int FRACTION = FXP_FRACTION,
  parameter int NODE_NUM = FXP_NODE_NUM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DATA_LEN-1:0] i_b_data,
  input  logic                i_l_valid,
  input  logic [DATA_LEN-1:0] i_l_data,
  output logic                o_busy,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_div0
);

  localparam int N       = mat_order(NODE_NUM);
  localparam int L_SIZE  = l_size(N);
  localparam int ACC_LEN = 2 * DATA_LEN;
  localparam int DIV_LAT = DATA_LEN + FRACTION + 2;
  localparam int RW      = $clog2(N + 1);
  localparam int CW      = $clog2(DIV_LAT);
  localparam int WW      = $clog2(L_SIZE);

  localparam logic [RW-1:0] LAST_IDX  = RW'(N - 1);
  localparam logic [RW-1:0] N_IDX     = RW'(N);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIV_LAT - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(L_SIZE - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                div0_q, div0_d;
  logic [RW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       row_q, row_d;
  logic [RW-1:0]       col_q, col_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ACC_LEN-1:0]  acc_q, acc_d;
  logic [DATA_LEN-1:0] b_q [N];
  logic [DATA_LEN-1:0] b_d [N];
  logic [DATA_LEN-1:0] y_q [N];
  logic [DATA_LEN-1:0] y_d [N];
  logic [DATA_LEN-1:0] d_q [N];
  logic [DATA_LEN-1:0] d_d [N];
  logic [DATA_LEN-1:0] z_q [N];
  logic [DATA_LEN-1:0] z_d [N];

  logic                       div_start;
  logic                       div_done;
  logic [DATA_LEN-1:0]        div_quot;
  logic [DATA_LEN+FRACTION-1:0] div_num;
  logic [DATA_LEN-1:0]        div_y;
  logic [DATA_LEN-1:0]        div_den;
  logic                       den_zero;
  logic [DATA_LEN-1:0]        zero_res;
  logic [ACC_LEN-1:0]         prod;
  logic signed [ACC_LEN-1:0]  term;
  logic [RW-1:0]              next_b;

  assign div_y    = y_q[idx_q];
  assign div_den  = d_q[idx_q];
  assign div_num  = {div_y, {FRACTION{1'b0}}};
  assign den_zero = (div_den == '0);
  assign zero_res = div_y[DATA_LEN-1] ? FXP_MIN : ((|div_y) ? FXP_MAX : '0);

  fxp_seq_div #(
    .DATA_LEN (DATA_LEN),
    .FRACTION (FRACTION)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (div_start),
    .i_num   (div_num),
    .i_den   (div_den),
    .o_done  (div_done),
    .o_quot  (div_quot)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    data_d    = data_q;
    div0_d    = div0_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    wcnt_d    = wcnt_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    y_d       = y_q;
    d_d       = d_q;
    z_d       = z_q;
    div_start = 1'b0;

    // Product of two Q.F words is Q.2F; the shift brings it back to Q.F.
    prod   = sext_acc(i_l_data) * sext_acc(y_q[col_q]);
    term   = $signed(prod) >>> FRACTION;
    next_b = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD_B;
          busy_d  = 1'b1;
          div0_d  = 1'b0;
          idx_d   = '0;
        end
      end

      ST_LOAD_B: begin
        b_d[idx_q] = i_b_data;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_WAIT_L;
          acc_d   = sext_acc(b_q[0]);
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          wcnt_d  = '0;
        end
      end

      ST_WAIT_L, ST_FWD: begin
        if (i_l_valid) begin
          state_d = ST_FWD;
          wcnt_d  = wcnt_q + 1'b1;
          if (col_q == row_q) begin
            y_d[row_q] = sat_acc(acc_q);
            d_d[row_q] = i_l_data;
            col_d      = '0;
            row_d      = row_q + 1'b1;
            acc_d      = (row_q == LAST_IDX) ? '0 : sext_acc(b_q[next_b]);
            if (wcnt_q == LAST_WORD) begin
              state_d = ST_DIV;
              idx_d   = '0;
              cnt_d   = '0;
            end
          end else begin
            acc_d = acc_q - term;
            col_d = col_q + 1'b1;
          end
        end
      end

      ST_DIV: begin
        // A zero divisor still occupies a full slot so the schedule never shifts.
        if (cnt_q == '0) begin
          div_start = !den_zero;
          if (den_zero) div0_d = 1'b1;
        end
        if (cnt_q == LAST_CNT) begin
          if (den_zero || div_done) z_d[idx_q] = den_zero ? zero_res : div_quot;
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_OUT;
            valid_d = 1'b1;
            data_d  = z_q[0];
            idx_d   = RW'(1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (idx_q == N_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          data_d  = '0;
          idx_d   = '0;
        end else begin
          data_d = z_q[idx_q];
          idx_d  = idx_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      div0_q  <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < N; k++) begin
        b_q[k] <= '0;
        y_q[k] <= '0;
        d_q[k] <= '0;
        z_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      div0_q  <= div0_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      y_q     <= y_d;
      d_q     <= d_d;
      z_q     <= z_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_div0  = div0_q;

endmodule

`default_nettype wire

// File: tb/tb_ldlt_fwd_solver.sv
// +----------------------------------------------------------------------+
// | tb_ldlt_fwd_solver                                                   |
// | Directed and randomized runs against a plain-arithmetic L.D.z=b model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ldlt_fwd_solver;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_b_data = '0;
  logic        i_l_valid = 1'b0;
  logic [31:0] i_l_data = '0;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_div0;

  ldlt_fwd_solver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_b_data  (i_b_data),
    .i_l_valid (i_l_valid),
    .i_l_data  (i_l_data),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_div0    (o_div0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  longint             tb_b [N];
  longint             tb_l [N][N];
  longint             tb_d [N];
  logic signed [31:0] exp_z [N];
  logic               exp_div0;
  logic [31:0]        exp_q [$];
  logic [31:0]        got [N];
  int                 nv = 0;
  logic               prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic signed [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'sh7FFFFFFF;
    if (v < -64'sd2147483648) return 32'sh80000000;
    return v[31:0];
  endfunction

  // Reference: y by forward substitution, then z = y / D with 0-divisor rules.
  task automatic model();
    longint acc;
    longint y [N];
    exp_div0 = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc = tb_b[i];
      for (int j = 0; j < i; j++) acc = acc - ((tb_l[i][j] * y[j]) >>> 16);
      y[i] = sat32(acc);
    end
    for (int i = 0; i < N; i++) begin
      if (tb_d[i] == 0) begin
        exp_div0 = 1'b1;
        exp_z[i] = (y[i] > 0) ? 32'sh7FFFFFFF : ((y[i] < 0) ? 32'sh80000000 : 32'sh0);
      end else begin
        exp_z[i] = sat32((y[i] * 65536) / tb_d[i]);
      end
    end
  endtask

  task automatic set_identity(input longint dval);
    for (int i = 0; i < N; i++) begin
      tb_b[i] = 65536 * (i + 1);
      tb_d[i] = dval;
      for (int j = 0; j < N; j++) tb_l[i][j] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (!prev_valid && nv != 0) begin
          tests++;
          fails++;
          $display("FAIL valid_contiguous: burst restarted after %0d words, required one burst", nv);
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_valid: got word %h, required no o_valid", o_data);
        end else begin
          check($sformatf("z[%0d]", nv), o_data, exp_q.pop_front());
        end
        if (nv < N) got[nv] = o_data;
        nv++;
      end else begin
        check("o_data_idle", o_data, 32'h0);
      end
      prev_valid = o_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    model();
    nv = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_z[i]);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", {31'b0, o_busy}, 32'd1);
    check("div0_cleared", {31'b0, o_div0}, 32'd0);
    for (int i = 0; i < N; i++) begin
      i_b_data = tb_b[i][31:0];
      tick();
    end
    i_b_data = '0;
  endtask

  // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle runs
  task automatic stream_l(input int gap_mode, input bit glitch, input int extras, input int max_words);
    int w = 0;
    int n;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c <= r; c++) begin
        if (w == max_words) return;
        i_l_valid = 1'b1;
        i_l_data  = (c < r) ? tb_l[r][c][31:0] : tb_d[r][31:0];
        if (glitch && w == 10) i_start = 1'b1;
        tick();
        i_start = 1'b0;
        w++;
        n = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 3)) : 0);
        i_l_valid = 1'b0;
        i_l_data  = $urandom;
        repeat (n) tick();
      end
    end
    repeat (extras) begin
      i_l_valid = 1'b1;
      i_l_data  = $urandom;
      tick();
    end
    i_l_valid = 1'b0;
    i_l_data  = '0;
  endtask

  task automatic finish_run(input string tag);
    int k = 0;
    while (!(nv >= N && !o_valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d output words, required %0d", tag, nv, N);
    end
    check({tag, "_valid_count"}, nv, N);
    check({tag, "_busy_end"}, {31'b0, o_busy}, 32'd0);
    check({tag, "_div0"}, {31'b0, o_div0}, {31'b0, exp_div0});
    tick();
  endtask

  task automatic full_run(input string tag, input int gap_mode, input bit glitch, input int extras);
    start_run();
    stream_l(gap_mode, glitch, extras, -1);
    finish_run(tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'h0);
    check("rst_div0", {31'b0, o_div0}, 32'd0);
    rst_n = 1'b1;
    tick();

    set_identity(65536);
    full_run("identity", 0, 1'b0, 0);
    for (int i = 0; i < N; i++) check($sformatf("identity_lit[%0d]", i), got[i], 65536 * (i + 1));

    set_identity(131072);
    full_run("scale2", 0, 1'b0, 0);
    for (int i = 0; i < N; i++) check($sformatf("scale2_lit[%0d]", i), got[i], 32768 * (i + 1));

    set_identity(65536);
    tb_b[1] = 65536;
    tb_l[1][0] = 32768;
    full_run("subst", 0, 1'b0, 0);
    check("subst_lit_z0", got[0], 32'd65536);
    check("subst_lit_z1", got[1], 32'd32768);
    check("subst_lit_z2", got[2], 32'd196608);

    set_identity(65536);
    for (int i = 0; i < N; i++) tb_b[i] = 65536;
    tb_d[2] = 0;
    model();
    check("model_div0_z2", exp_z[2], 32'h7FFFFFFF);
    full_run("div0", 0, 1'b0, 0);
    check("div0_lit_z2", got[2], 32'h7FFFFFFF);
    check("div0_lit_flag", {31'b0, o_div0}, 32'd1);

    set_identity(65536);
    full_run("div0_clear", 0, 1'b0, 0);

    full_run("gaps_glitch_extra", 1, 1'b1, 5);
    for (int i = 0; i < N; i++) check($sformatf("gaps_lit[%0d]", i), got[i], 65536 * (i + 1));

    // Asynchronous reset in the middle of the L stream
    set_identity(65536);
    start_run();
    stream_l(0, 1'b0, 0, 8);
    check("pre_reset_busy", {31'b0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, o_busy}, 32'd0);
    check("midrst_valid", {31'b0, o_valid}, 32'd0);
    check("midrst_data", o_data, 32'h0);
    check("midrst_div0", {31'b0, o_div0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    nv = 0;
    tick();
    full_run("after_reset", 0, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        tb_b[i] = longint'($urandom_range(0, 524288)) - 262144;
        for (int j = 0; j < N; j++) tb_l[i][j] = longint'($urandom_range(0, 131072)) - 65536;
        tb_d[i] = 32768 + longint'($urandom_range(0, 98304));
        if ($urandom_range(0, 1) == 1) tb_d[i] = -tb_d[i];
        if ($urandom_range(0, 7) == 0) tb_d[i] = 0;
      end
      full_run($sformatf("rand%0d", t), 2, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
